hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage core.
- Drives the stall/flush controls of every inter-stage pipeline register (F→D, D→E, E→M, M→W) and the E-stage forwarding muxes.
- Owns a small FSM that freezes the pipeline while a data-memory access in M is not ready, with a bounded-wait timeout leading to a sticky fault.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding, load-use interlock, branch flush and
// memory-wait freeze with a timeout fault. HAZARD_PERF_EN adds stall/redirect counters.
module hazard_fwd #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  output logic [1:0]       fwd
);
  always_comb begin
    fwd = 2'b00;
    if (regwrite_w && (rd_w != '0) && (rd_w == rs)) fwd = 2'b01;
    // M is the younger producer, so it overrides W
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) fwd = 2'b10;
  end
endmodule

module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             MemReadE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             dmem_reqM,
  input  logic             dmem_readyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             RedirectF,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             fault_o,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_redirects
);
  localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam int NSRC  = 2;

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_hit, mem_hold, lw;

  logic [NSRC-1:0][REG_W-1:0] src_e;
  logic [NSRC-1:0][1:0]       fwd;

  assign src_e     = {Rs2E, Rs1E};
  assign ForwardAE = fwd[0];
  assign ForwardBE = fwd[1];

  for (genvar i = 0; i < NSRC; i++) begin : g_fwd
    hazard_fwd #(.REG_W(REG_W)) u_fwd (
      .rs(src_e[i]), .rd_m(RdM), .rd_w(RdW),
      .regwrite_m(RegWriteM), .regwrite_w(RegWriteW), .fwd(fwd[i])
    );
  end

  // cnt holds the number of not-ready cycles already completed in this wait
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt == CNT_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: if (dmem_reqM && !dmem_readyM) begin
        state_nxt = MEM_WAIT;
        cnt_nxt   = CNT_W'(1);
      end
      MEM_WAIT: begin
        if (dmem_readyM) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (timeout_hit) begin
          state_nxt = FAULT;
        end else if (cnt != '1) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      FAULT:   state_nxt = FAULT;
      default: state_nxt = RUN;
    endcase
  end

  assign mem_hold = (state == FAULT) || (dmem_reqM && !dmem_readyM);
  assign lw       = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign fault_o  = (state == FAULT);

  always_comb begin
    StallF = 1'b0; StallD = 1'b0; StallE = 1'b0; StallM = 1'b0;
    FlushD = 1'b0; FlushE = 1'b0; FlushW = 1'b0; RedirectF = 1'b0;
    if (mem_hold) begin
      {StallF, StallD, StallE, StallM, FlushW} = '1;
    end else if (PCSrcE) begin
      // wrong-path instruction in D makes any load-use match irrelevant
      {FlushD, FlushE, RedirectF} = '1;
    end else if (lw) begin
      {StallF, StallD, FlushE} = '1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
    end else begin
      if (StallF && (perf_stall_cycles != '1)) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (RedirectF && (perf_redirects != '1)) perf_redirects <= perf_redirects + 32'd1;
    end
  end
`else
  assign perf_stall_cycles = '0;
  assign perf_redirects    = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MEM_TIMEOUT=4).
module tb_hazard_ctrl;
  localparam int REG_W = 5;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic MemReadE, RegWriteM, RegWriteW, PCSrcE, dmem_reqM, dmem_readyM;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, RedirectF, fault_o;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] perf_stall_cycles, perf_redirects;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(REG_W), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .MemReadE(MemReadE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .dmem_reqM(dmem_reqM), .dmem_readyM(dmem_readyM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .RedirectF(RedirectF),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .fault_o(fault_o),
    .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects)
  );

  // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,RedirectF}
  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_HOLD = 8'b1111_0010;
  localparam logic [7:0] C_BR   = 8'b0000_1101;
  localparam logic [7:0] C_LU   = 8'b1100_0100;

  function automatic logic [7:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, RedirectF};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {MemReadE, RegWriteM, RegWriteW, PCSrcE, dmem_reqM, dmem_readyM} = '0;
  endtask

  // inputs change on the falling edge; checks sit 1ns later, far from posedge
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    clr();
    @(negedge clk); #1;
    chk("rst_ctl", 32'(ctl()), 32'(C_NONE));
    chk("rst_fault", 32'(fault_o), 0);
    chk("rst_perf", perf_stall_cycles | perf_redirects, 0);
    step(); rst_n = 1'b1;

    // forwarding
    RegWriteM = 1; RegWriteW = 1; RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; #1;
    chk("fwdA_m_pri", 32'(ForwardAE), 32'(2'b10));
    chk("fwdB_m_pri", 32'(ForwardBE), 32'(2'b10));
    step(); RdM = 0; #1;
    chk("fwdA_w", 32'(ForwardAE), 32'(2'b01));
    step(); RdM = 3; Rs2E = 3; #1;
    chk("fwdB_m_only", 32'(ForwardBE), 32'(2'b10));
    chk("fwdA_w_rdm3", 32'(ForwardAE), 32'(2'b01));
    step(); RegWriteM = 0; Rs2E = 5; #1;
    chk("fwdB_w_nowrm", 32'(ForwardBE), 32'(2'b01));
    step(); Rs1E = 0; RdW = 0; #1;
    chk("fwdA_x0", 32'(ForwardAE), 32'(2'b00));
    chk("fwd_ctl", 32'(ctl()), 32'(C_NONE));
    step(); clr();

    // load-use for one cycle, then the load is in M
    MemReadE = 1; RdE = 7; Rs2D = 7; #1;
    chk("lu", 32'(ctl()), 32'(C_LU));
    step(); MemReadE = 0; RdE = 0; RdM = 7; #1;
    chk("lu_next", 32'(ctl()), 32'(C_NONE));
    step(); clr(); MemReadE = 1; RdE = 0; Rs1D = 0; #1;
    chk("lu_x0", 32'(ctl()), 32'(C_NONE));

    // branch beats load-use
    step(); clr(); MemReadE = 1; RdE = 9; Rs1D = 9; PCSrcE = 1; #1;
    chk("br_over_lu", 32'(ctl()), 32'(C_BR));

    // 3-cycle memory wait with a stalled branch in E
    step(); clr(); dmem_reqM = 1; PCSrcE = 1;
    for (int i = 0; i < 3; i++) begin
      #1; chk($sformatf("wait%0d", i), 32'(ctl()), 32'(C_HOLD));
      step();
    end
    dmem_readyM = 1; #1;
    chk("wait_done", 32'(ctl()), 32'(C_BR));
    step(); clr(); dmem_reqM = 1; dmem_readyM = 1; #1;
    chk("wait_run", 32'(ctl()), 32'(C_NONE));
    chk("wait_nofault", 32'(fault_o), 0);
    step(); clr(); #1;
`ifdef HAZARD_PERF_EN
    chk("perf_stall", perf_stall_cycles, 4);
    chk("perf_redir", perf_redirects, 2);
`else
    chk("perf_stall", perf_stall_cycles, 0);
    chk("perf_redir", perf_redirects, 0);
`endif

    // ready on the successor of the 4th low cycle completes normally
    dmem_reqM = 1;
    for (int i = 0; i < 4; i++) begin
      #1; chk($sformatf("to_edge%0d", i), 32'(ctl()), 32'(C_HOLD));
      step();
    end
    dmem_readyM = 1; #1;
    chk("to_edge_ok", 32'(ctl()), 32'(C_NONE));
    step(); clr(); #1;
    chk("to_edge_nofault", 32'(fault_o), 0);

    // five consecutive low cycles -> sticky fault
    dmem_reqM = 1;
    for (int i = 0; i < 5; i++) begin
      #1; chk($sformatf("to_fault%0d", i), 32'(fault_o), 0);
      step();
    end
    #1; chk("fault_set", 32'(fault_o), 1);
    dmem_readyM = 1; #1;
    chk("fault_hold_rdy", 32'(ctl()), 32'(C_HOLD));
    step(); clr(); PCSrcE = 1; #1;
    chk("fault_hold_br", 32'(ctl()), 32'(C_HOLD));
    chk("fault_sticky", 32'(fault_o), 1);
    rst_n = 1'b0; #1;
    chk("fault_async_clr", 32'(fault_o), 0);
    chk("rst_run_br", 32'(ctl()), 32'(C_BR));
    step(); rst_n = 1'b1; clr(); #1;
    chk("post_rst", 32'(ctl()), 32'(C_NONE));
    chk("post_rst_perf", perf_stall_cycles | perf_redirects, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
